uart_txd: RTL and testbench

UART transmitter for the 50 MHz board clock; serialises one byte per request onto txd_pin as 8N1 (start, 8 data LSB first, stop).
Companion to uart_rxd: same clock, reset and baud defaults, so a txd_pin to rxd_pin loopback round-trips bytes.
Sits between user logic, which presents a byte plus a start pulse, and the board TX pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_txd.sv | 115 +++++++++++
 tb/tb_uart_txd.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default clock/baud, frame constants.
// Used by uart_txd and uart_rxd so both ends of a loopback agree on timing.
package uart_pkg;

  localparam int   DEF_CLK_FREQ = 50_000_000;
  localparam int   DEF_BAUD     = 9600;
  localparam int   DATA_BITS    = 8;
  localparam logic IDLE_LVL     = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: wraps every BAUD_DIV cycles, bit_tick marks the last cycle of a bit.
// clear realigns the bit grid to the frame start.
module uart_baud_gen #(
  parameter int BAUD_DIV = 5208
) (
  input  logic clk50M,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_baud_gen: BAUD_DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk50M) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_txd.sv
// UART transmitter, 8N1 LSB first; define UART_TXD_PARITY_EN for an even-parity bit
// between the last data bit and the stop bit (8E1).
module uart_txd
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD,
  parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic [7:0] txd_data,
  input  logic       txd_en,
  output logic       txd_pin,
  output logic       txd_busy,
  output logic       txd_done
);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 bit_tick;
  logic                 accept;
`ifdef UART_TXD_PARITY_EN
  logic                 par_bit;
`endif

  assign accept = (state == IDLE) && txd_en;

  uart_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk50M  (clk50M),
    .rst_n   (rst_n),
    .clear   (accept),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk50M) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      txd_pin  <= IDLE_LVL;
      txd_busy <= 1'b0;
      txd_done <= 1'b0;
`ifdef UART_TXD_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      txd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (txd_en) begin
            state    <= START;
            shift    <= txd_data;
            txd_pin  <= ~IDLE_LVL;
            txd_busy <= 1'b1;
`ifdef UART_TXD_PARITY_EN
            par_bit  <= even_parity(txd_data);
`endif
          end
        end
        START: begin
          if (bit_tick) begin
            state   <= DATA;
            txd_pin <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              bit_idx <= '0;
`ifdef UART_TXD_PARITY_EN
              state   <= PARITY;
              txd_pin <= par_bit;
`else
              state   <= STOP;
              txd_pin <= IDLE_LVL;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd_pin <= shift[0];
              shift   <= shift >> 1;
            end
          end
        end
`ifdef UART_TXD_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            state   <= STOP;
            txd_pin <= IDLE_LVL;
          end
        end
`endif
        STOP: begin
          // Leave via IDLE so a request in the done cycle starts the next frame.
          if (bit_tick) begin
            state    <= IDLE;
            txd_busy <= 1'b0;
            txd_done <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          txd_pin  <= IDLE_LVL;
          txd_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_txd.sv
// Randomized bench for uart_txd with a frame-timeline reference model (honours UART_TXD_PARITY_EN).
module tb_uart_txd;

  localparam int B = 7;
`ifdef UART_TXD_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] txd_data = 8'h00;
  logic       txd_en = 1'b0;
  logic       txd_pin, txd_busy, txd_done;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int cyc = 0;

  uart_txd #(
    .CLK_FREQ(70),
    .BAUD    (10)
  ) dut (
    .clk50M  (clk),
    .rst_n   (rst_n),
    .txd_data(txd_data),
    .txd_en  (txd_en),
    .txd_pin (txd_pin),
    .txd_busy(txd_busy),
    .txd_done(txd_done)
  );

  always #5 clk = ~clk;

  // Reference: a frame is a list of FB line levels, each held B cycles from the accept edge.
  bit m_active = 0;
  int m_start = 0;
  int el;
  bit m_bits[0:10];
  bit e_pin = 1, e_busy = 0, e_done = 0;

  always @(posedge clk) begin
    cyc++;
    e_done = 0;
    if (!rst_n) begin
      m_active = 0; e_pin = 1; e_busy = 0;
    end else if (m_active) begin
      el = cyc - m_start;
      if (el >= FB * B) begin
        m_active = 0; e_pin = 1; e_busy = 0; e_done = 1;
      end else begin
        e_pin = m_bits[el / B];
      end
    end else if (txd_en) begin
      m_active = 1; m_start = cyc; e_pin = 0; e_busy = 1;
      m_bits[0] = 0;
      for (int i = 0; i < 8; i++) m_bits[1 + i] = txd_data[i];
`ifdef UART_TXD_PARITY_EN
      m_bits[9] = ^txd_data;
`endif
      m_bits[FB - 1] = 1;
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      vectors++;
      if (txd_pin !== e_pin || txd_busy !== e_busy || txd_done !== e_done) begin
        miscompares++;
        $display("FAIL model cyc=%0d got pin=%b busy=%b done=%b expected pin=%b busy=%b done=%b",
                 cyc, txd_pin, txd_busy, txd_done, e_pin, e_busy, e_done);
      end
      if (txd_done === 1'b1) done_cnt++;
    end
  end

  function automatic void check1(input string nm, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%b expected=%b (cyc %0d)", nm, got, exp, cyc);
    end
  endfunction

  function automatic void check_int(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endfunction

  // Called at a negedge with the DUT idle; seq[s] is the required level of bit slot s.
  task automatic send_and_check(input logic [7:0] d, input logic [10:0] seq, input string nm);
    txd_data = d; txd_en = 1;
    @(negedge clk);
    txd_en = 0; txd_data = 8'($urandom);
    for (int k = 0; k < FB * B; k++) begin
      if (k % B == B / 2) begin
        check1($sformatf("%s_slot%0d", nm, k / B), txd_pin, seq[k / B]);
        check1($sformatf("%s_busy%0d", nm, k / B), txd_busy, 1'b1);
      end
      @(negedge clk);
    end
    check1({nm, "_done"}, txd_done, 1'b1);
    check1({nm, "_busy_end"}, txd_busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] d);
    txd_data = d; txd_en = 1;
    @(negedge clk);
    txd_en = 0; txd_data = 8'($urandom);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (txd_done !== 1'b1 && n < FB * B + 5) begin
      @(negedge clk);
      n++;
    end
    check1(nm, txd_done, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int c1, c2, d0;
    logic [10:0] seq55, seq81, seq07, seq03;
`ifdef UART_TXD_PARITY_EN
    seq55 = 11'b10010101010;
    seq81 = 11'b10100000010;
    seq07 = 11'b11000001110;
    seq03 = 11'b10000000110;
`else
    seq55 = 11'b01010101010;
    seq81 = 11'b01100000010;
    seq07 = 11'b01000001110;
    seq03 = 11'b01000000110;
`endif

    // Reset state
    repeat (3) begin
      @(negedge clk);
      check1("rst_pin", txd_pin, 1'b1);
      check1("rst_busy", txd_busy, 1'b0);
      check1("rst_done", txd_done, 1'b0);
    end
    rst_n = 1;
    idle_cycles(4);

    send_and_check(8'h55, seq55, "b55");
    idle_cycles(3);
    send_and_check(8'h07, seq07, "b07");
    send_and_check(8'h03, seq03, "b03");

    // Back-to-back via request in the done cycle
    d0 = done_cnt;
    pulse(8'hA3);
    wait_done("b2b_first");
    c1 = cyc;
    txd_data = 8'h0F; txd_en = 1;
    @(negedge clk);
    txd_en = 0;
    wait_done("b2b_second");
    c2 = cyc;
    check_int("b2b_spacing", c2 - c1, FB * B + 1);
    @(negedge clk);
    check_int("b2b_done_count", done_cnt - d0, 2);

    // Request while busy is dropped
    idle_cycles(5);
    d0 = done_cnt;
    pulse(8'h3C);
    idle_cycles(20);
    pulse(8'hFF);
    wait_done("busy_ign_done");
    idle_cycles(2 * FB * B);
    check_int("busy_ign_count", done_cnt - d0, 1);

    // Reset during data bit 4
    d0 = done_cnt;
    pulse(8'h81);
    idle_cycles(5 * B + 2);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check1("midrst_pin", txd_pin, 1'b1);
    check1("midrst_busy", txd_busy, 1'b0);
    idle_cycles(FB * B + 5);
    check_int("midrst_no_done", done_cnt - d0, 0);
    send_and_check(8'h81, seq81, "b81");

    // Long idle
    d0 = done_cnt;
    idle_cycles(200);
    check_int("idle_no_done", done_cnt - d0, 0);
    check1("idle_pin", txd_pin, 1'b1);

    // Level-held request
    d0 = done_cnt;
    txd_en = 1;
    for (int i = 0; i < 3 * (FB * B + 1); i++) begin
      txd_data = 8'($urandom);
      @(negedge clk);
    end
    txd_en = 0;
    idle_cycles(FB * B + 3);
    check_int("level_done_count", done_cnt - d0, 3);

    // Random traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      txd_data = 8'($urandom);
      txd_en = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end
    txd_en = 0; rst_n = 1;
    idle_cycles(FB * B + 3);
    check1("final_idle_busy", txd_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
